// File: rtl/cal_field_counter.sv
// cal_field_counter: one calendar/clock field counting between MIN_VAL and a static or run-time upper limit.
//   i_clk        system clock, all state updates on the rising edge
//   i_clear      synchronous active-high reset (value=RESET_VAL, carry and error cleared)
//   i_load       parallel-load strobe, range-checked against the effective maximum
//   i_data       parallel-load value
//   i_enable     databus output enable
//   i_count_in   carry/borrow-in from the next-lower field, one pulse = one step
//   i_dir        0 = count up, 1 = count down
//   i_limit_max  run-time upper limit, only used when USE_DYN_MAX=1
//   o_value      registered current count
//   o_databus    o_value gated by i_enable, zero otherwise
//   o_carry_out  registered one-cycle wrap/borrow pulse to the next-higher field
//   o_at_limit   high when the next step in the current direction wraps
//   o_load_err   sticky flag: the last load was out of range
module cal_field_counter #(
    parameter int WIDTH       = 6,
    parameter int MIN_VAL     = 1,
    parameter int MAX_VAL     = 60,
    parameter int RESET_VAL   = 1,
    parameter bit USE_DYN_MAX = 0
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_enable,
    input  logic             i_count_in,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_limit_max,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_databus,
    output logic             o_carry_out,
    output logic             o_at_limit,
    output logic             o_load_err
);
    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_value;
    logic             r_carry;
    logic             r_load_err;
    logic [WIDTH-1:0] w_eff_max;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_carry;
    logic             w_next_err;
    logic             w_at_max;
    logic             w_at_min;

    // The run-time limit is clipped so a bad limit can never push the count outside the static range.
    assign w_eff_max = !USE_DYN_MAX ? L_MAX :
                       (i_limit_max < L_MIN) ? L_MIN :
                       (i_limit_max > L_MAX) ? L_MAX : i_limit_max;
    assign w_at_max  = r_value >= w_eff_max;
    assign w_at_min  = r_value <= L_MIN;

    // Load beats a count step (the step is dropped); a value stranded above a lowered limit is pulled down when idle.
    always_comb begin
        w_next_value = r_value;
        w_next_carry = 1'b0;
        w_next_err   = r_load_err;
        if (i_load) begin
            if (i_data >= L_MIN && i_data <= w_eff_max) begin
                w_next_value = i_data;
                w_next_err   = 1'b0;
            end else begin
                w_next_err   = 1'b1;
            end
        end else if (i_count_in) begin
            w_next_carry = i_dir ? w_at_min : w_at_max;
            w_next_value = i_dir ? (w_at_min ? w_eff_max : r_value - 1'b1)
                                 : (w_at_max ? L_MIN : r_value + 1'b1);
        end else if (r_value > w_eff_max) begin
            w_next_value = w_eff_max;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_value    <= L_RST;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_value    <= w_next_value;
            r_carry    <= w_next_carry;
            r_load_err <= w_next_err;
        end
    end

    assign o_value     = r_value;
    assign o_databus   = i_enable ? r_value : '0;
    assign o_carry_out = r_carry;
    assign o_at_limit  = i_dir ? w_at_min : w_at_max;
    assign o_load_err  = r_load_err;
endmodule

// File: tb/tb_cal_field_counter.sv
// tb_cal_field_counter: scoreboard bench for a default field (1..60) and a dynamic-limit field (1..31).
module tb_cal_field_counter;
    typedef struct {
        string      name;
        bit         sel;
        logic [5:0] v;
        logic       c;
        logic       al;
        logic       e;
        logic [5:0] bus;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1, load = 1'b0, enable = 1'b0, count_in = 1'b0, dir = 1'b0;
    logic [5:0] data = '0, limit_max = 6'd31;
    logic [5:0] a_value, a_bus, b_value, b_bus;
    logic       a_carry, a_al, a_err, b_carry, b_al, b_err;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    cal_field_counter u_a (
        .i_clk(clk), .i_clear(clear), .i_load(load), .i_data(data), .i_enable(enable),
        .i_count_in(count_in), .i_dir(dir), .i_limit_max(limit_max),
        .o_value(a_value), .o_databus(a_bus), .o_carry_out(a_carry), .o_at_limit(a_al), .o_load_err(a_err)
    );

    cal_field_counter #(.WIDTH(6), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(1), .USE_DYN_MAX(1)) u_b (
        .i_clk(clk), .i_clear(clear), .i_load(load), .i_data(data), .i_enable(enable),
        .i_count_in(count_in), .i_dir(dir), .i_limit_max(limit_max),
        .o_value(b_value), .o_databus(b_bus), .o_carry_out(b_carry), .o_at_limit(b_al), .o_load_err(b_err)
    );

    task automatic check(input string n, input string f, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
        end
    endtask

    // Each entry describes the state visible between the edge just passed and the next one.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check(x.name, "value",     x.sel ? b_value : a_value, x.v);
            check(x.name, "carry_out", {5'd0, x.sel ? b_carry : a_carry}, {5'd0, x.c});
            check(x.name, "at_limit",  {5'd0, x.sel ? b_al : a_al}, {5'd0, x.al});
            check(x.name, "load_err",  {5'd0, x.sel ? b_err : a_err}, {5'd0, x.e});
            check(x.name, "databus",   x.sel ? b_bus : a_bus, x.bus);
        end
    end

    task automatic cyc(input logic clr, input logic ld, input logic [5:0] d, input logic en,
                       input logic ci, input logic dr, input logic [5:0] lm,
                       input bit chk, input bit sel, input string n,
                       input logic [5:0] v, input logic c, input logic al, input logic e, input logic [5:0] bus);
        exp_t x;
        @(posedge clk);
        #1;
        clear = clr; load = ld; data = d; enable = en; count_in = ci; dir = dr; limit_max = lm;
        if (chk) begin
            x.name = n; x.sel = sel; x.v = v; x.c = c; x.al = al; x.e = e; x.bus = bus;
            sb.push_back(x);
        end
    endtask

    initial begin
        //  clr ld data en ci dr lim  chk sel name           v  c al e bus
        cyc(0, 0, 0,  0, 1, 0, 31, 1, 0, "reset",       1, 0, 0, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 31, 1, 0, "first_step",  2, 0, 0, 0, 0);
        cyc(0, 1, 59, 0, 0, 0, 31, 1, 0, "pre_load59",  2, 0, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 31, 1, 0, "load59",     59, 0, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 31, 1, 0, "at60",       60, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 31, 1, 0, "up_wrap",     1, 1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 1, 31, 1, 0, "carry_once",  1, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 31, 1, 0, "down_wrap",  60, 1, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 31, 1, 0, "dir_switch",  1, 1, 0, 0, 0);
        cyc(0, 1, 0,  0, 0, 0, 31, 1, 0, "pre_load0",   1, 0, 0, 0, 0);
        cyc(0, 1, 61, 0, 0, 0, 31, 1, 0, "load0_err",   1, 0, 0, 1, 0);
        cyc(0, 1, 30, 0, 1, 0, 31, 1, 0, "load61_err",  1, 0, 0, 1, 0);
        cyc(1, 1, 45, 0, 0, 0, 31, 1, 0, "load30_cin", 30, 0, 0, 0, 0);
        cyc(0, 1, 45, 0, 0, 0, 31, 1, 0, "clear_load",  1, 0, 0, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 31, 1, 0, "bus_off",    45, 0, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 31, 1, 0, "bus_on",     45, 0, 0, 0, 45);
        cyc(0, 0, 0,  0, 0, 0, 31, 1, 0, "bus_off2",   45, 0, 0, 0, 0);
        cyc(1, 0, 0,  0, 0, 0, 31, 0, 1, "",            0, 0, 0, 0, 0);
        cyc(0, 1, 31, 0, 0, 0, 31, 1, 1, "dyn_reset",   1, 0, 0, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 28, 1, 1, "dyn_31",     31, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 28, 1, 1, "dyn_clamp",  28, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 28, 1, 1, "dyn_wrap",    1, 1, 0, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 0,  1, 1, "dyn_clip_lo", 1, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0,  1, 1, "dyn_lo_cin",  1, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 40, 1, 1, "dyn_clip_hi", 1, 1, 0, 0, 0);
        cyc(0, 1, 31, 0, 0, 0, 40, 1, 1, "dyn_hi_ld",   1, 0, 0, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 40, 1, 1, "dyn_hi_31",  31, 0, 1, 0, 0);
        cyc(0, 1, 29, 0, 0, 0, 28, 1, 1, "dyn_ld29",   31, 0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 28, 1, 1, "dyn_err",    31, 0, 1, 1, 0);
        cyc(0, 0, 0,  0, 1, 0, 28, 1, 1, "dyn_clamp2", 28, 0, 1, 1, 0);
        cyc(0, 0, 0,  0, 0, 0, 28, 1, 1, "dyn_sticky",  1, 1, 0, 1, 0);
        cyc(0, 0, 0,  0, 0, 0, 28, 0, 0, "",            0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
